// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: op codes, rounding-op set,
// FSM encoding and accrued-flag bit positions.
package fpu_ctrl_pkg;

  localparam int OP_W   = 5;
  localparam int RM_W   = 3;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 5;
  localparam int FLAG_W = 5;

  localparam logic [OP_W-1:0] OP_FADD     = 5'b00000;
  localparam logic [OP_W-1:0] OP_FSUB     = 5'b00001;
  localparam logic [OP_W-1:0] OP_FMUL     = 5'b00010;
  localparam logic [OP_W-1:0] OP_FDIV     = 5'b00011;
  localparam logic [OP_W-1:0] OP_FSGNJ    = 5'b00100;
  localparam logic [OP_W-1:0] OP_FMINMAX  = 5'b00101;
  localparam logic [OP_W-1:0] OP_FSQRT    = 5'b01011;
  localparam logic [OP_W-1:0] OP_FCMP     = 5'b10100;
  localparam logic [OP_W-1:0] OP_FCVT_W_S = 5'b11000;
  localparam logic [OP_W-1:0] OP_FCVT_S_W = 5'b11010;
  localparam logic [OP_W-1:0] OP_FMV_X_W  = 5'b11100;
  localparam logic [OP_W-1:0] OP_FMV_W_X  = 5'b11110;

  // Ops whose rm field is a real rounding mode (and so may be dynamic).
  localparam int N_ROUND_OPS = 7;
  localparam logic [OP_W-1:0] ROUND_OPS [0:N_ROUND_OPS-1] = '{
    OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT, OP_FCVT_W_S, OP_FCVT_S_W
  };

  localparam logic [RM_W-1:0] RM_DYN = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  function automatic logic is_rounding_op(input logic [OP_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ROUND_OPS; i++) begin
      if (ROUND_OPS[i] == op) hit = 1'b1;
    end
    return hit;
  endfunction

  // 101 and 110 are reserved; 111 left over after resolution means frm itself was dynamic.
  function automatic logic rm_is_reserved(input logic [RM_W-1:0] rm);
    return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
  endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the effective rounding mode of a request and flags illegal modes.
// Non-rounding ops carry a function select in rm, which is passed untouched.
module fpu_rm_resolve
  import fpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [RM_W-1:0] rm,
  input  logic [RM_W-1:0] frm,
  output logic [RM_W-1:0] rm_out,
  output logic            illegal
);

  logic rounding;

  // Substitute frm for a dynamic rm on rounding ops, then check legality.
  always_comb begin
    rounding = is_rounding_op(op);
    rm_out   = rm;
    if (rounding && (rm == RM_DYN)) rm_out = frm;
    illegal  = rounding && rm_is_reserved(rm_out);
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller between the core and the FPU arithmetic unit: holds one
// request, drives the start/operand interface, returns a single response and
// keeps the sticky accrued exception flags.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [RM_W-1:0]   req_rm,
  input  logic              req_rs2_lsb,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic [TAG_W-1:0]  req_rd,
  input  logic [RM_W-1:0]   frm,
  input  logic              flush,
  output logic              fpu_start,
  output logic [OP_W-1:0]   fpu_op,
  output logic [RM_W-1:0]   fpu_rm,
  output logic              fpu_rs2_lsb,
  output logic [XLEN-1:0]   fpu_a,
  output logic [XLEN-1:0]   fpu_b,
  input  logic              fpu_done,
  input  logic [XLEN-1:0]   fpu_result,
  input  logic [FLAG_W-1:0] fpu_flags,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_rd,
  output logic [FLAG_W-1:0] resp_flags,
  output logic              resp_illegal,
  output logic [FLAG_W-1:0] fflags_acc,
  input  logic              fflags_clr
);

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [RM_W-1:0]   rm_q;
  logic              rs2_lsb_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [TAG_W-1:0]  rd_q;

  logic [RM_W-1:0]   rm_res;
  logic              rm_illegal;
  logic              accept;
  logic              resp_hs;

  fpu_rm_resolve u_rm_resolve (
    .op      (req_op),
    .rm      (req_rm),
    .frm     (frm),
    .rm_out  (rm_res),
    .illegal (rm_illegal)
  );

  assign req_ready = (state == IDLE) && !flush && !reset;
  assign accept    = req_valid && req_ready;
  assign resp_hs   = (state == RESP) && resp_ready;

  // The arithmetic unit only ever sees the held copy of the request.
  assign fpu_op      = op_q;
  assign fpu_rm      = rm_q;
  assign fpu_rs2_lsb = rs2_lsb_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;

  // Control FSM with registered start/response outputs and accrued flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fpu_start    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_illegal <= 1'b0;
      resp_data    <= '0;
      resp_rd      <= '0;
      resp_flags   <= '0;
      fflags_acc   <= '0;
      op_q         <= '0;
      rm_q         <= '0;
      rs2_lsb_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rd_q         <= '0;
    end else if (flush) begin
      // Kill whatever is in flight; the accrued flags are left as they were.
      state      <= IDLE;
      fpu_start  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            rm_q      <= rm_res;
            rs2_lsb_q <= req_rs2_lsb;
            a_q       <= req_a;
            b_q       <= req_b;
            rd_q      <= req_rd;
            if (rm_illegal) begin
              // Illegal rounding mode never reaches the arithmetic unit.
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_illegal <= 1'b1;
              resp_data    <= '0;
              resp_flags   <= '0;
              resp_rd      <= req_rd;
            end else begin
              state     <= EXEC;
              fpu_start <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (fpu_done) begin
            state        <= RESP;
            fpu_start    <= 1'b0;
            resp_valid   <= 1'b1;
            resp_illegal <= 1'b0;
            resp_data    <= fpu_result;
            resp_flags   <= fpu_flags;
            resp_rd      <= rd_q;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          fpu_start  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase

      // A clear coinciding with a handshake keeps only this op's flags.
      if (resp_hs) begin
        fflags_acc <= fflags_clr ? resp_flags : (fflags_acc | resp_flags);
      end else if (fflags_clr) begin
        fflags_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a stub arithmetic unit and a
// scoreboard of expected responses popped by a negedge monitor.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
  import fpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [2:0]  req_rm = '0;
  logic        req_rs2_lsb = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic [2:0]  frm = '0;
  logic        flush = 1'b0;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic        fpu_rs2_lsb;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [4:0]  resp_flags;
  logic        resp_illegal;
  logic [4:0]  fflags_acc;
  logic        fflags_clr = 1'b0;

  fpu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_rs2_lsb(req_rs2_lsb), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .frm(frm), .flush(flush),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_rs2_lsb(fpu_rs2_lsb),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .fpu_flags(fpu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_flags(resp_flags), .resp_illegal(resp_illegal),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  // Stub arithmetic unit: done after stub_lat extra start cycles.
  int          stub_lat = 0;
  int          stub_cnt = 0;
  logic [31:0] stub_result = '0;
  logic [4:0]  stub_flags = '0;
  assign fpu_done   = fpu_start && (stub_cnt == stub_lat);
  assign fpu_result = stub_result;
  assign fpu_flags  = stub_flags;
  always @(posedge clk) stub_cnt <= (fpu_start && !fpu_done) ? stub_cnt + 1 : 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [4:0]  flags;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   start_total = 0;
  int   base;
  int   lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic [4:0] fl,
                      input logic ill);
    exp_t e;
    e.data = d; e.rd = rd; e.flags = fl; e.illegal = ill;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; returns 1ns after the accept edge.
  task automatic send(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    int n;
    req_op = op; req_rm = rm; req_a = a; req_b = b; req_rd = rd; req_rs2_lsb = 1'b0;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    chk("accept", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count negedges until resp_valid is seen (bounded).
  task automatic wait_resp(output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!resp_valid && l < 100);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (fpu_start) start_total++;
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: got rd %0d data %h, required no response",
                     resp_rd, resp_data);
          end else begin
            mon_e = sb.pop_front();
            chk("resp_data", resp_data, mon_e.data);
            chk("resp_rd", 32'(resp_rd), 32'(mon_e.rd));
            chk("resp_flags", 32'(resp_flags), 32'(mon_e.flags));
            chk("resp_illegal", 32'(resp_illegal), 32'(mon_e.illegal));
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_fpu_start", 32'(fpu_start), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_fflags_acc", 32'(fflags_acc), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;

    // FADD, single-cycle stub
    stub_lat = 0; stub_result = 32'h40400000; stub_flags = 5'b00000;
    push(32'h40400000, 5'd1, 5'b00000, 1'b0);
    base = start_total;
    send(OP_FADD, 3'b000, 32'h3F800000, 32'h40000000, 5'd1);
    wait_resp(lat);
    chk("fadd_latency", 32'(lat), 32'd2);
    tick();
    @(negedge clk);
    chk("fadd_acc", 32'(fflags_acc), 32'h00);
    tick();
    chk("fadd_starts", 32'(start_total - base), 32'd1);

    // FDIV by zero, 12 extra cycles, DZ
    stub_lat = 12; stub_result = 32'h7F800000; stub_flags = 5'b01000;
    push(32'h7F800000, 5'd2, 5'b01000, 1'b0);
    base = start_total;
    send(OP_FDIV, 3'b000, 32'h3F800000, 32'h00000000, 5'd2);
    wait_resp(lat);
    chk("fdiv_latency", 32'(lat), 32'd14);
    tick();
    @(negedge clk);
    chk("fdiv_acc", 32'(fflags_acc), 32'h08);
    tick();
    chk("fdiv_starts", 32'(start_total - base), 32'd13);

    // Dynamic rm resolves to frm=010
    frm = 3'b010;
    stub_lat = 2; stub_result = 32'h40C00000; stub_flags = 5'b00001;
    push(32'h40C00000, 5'd3, 5'b00001, 1'b0);
    send(OP_FMUL, 3'b111, 32'h40000000, 32'h40400000, 5'd3);
    @(negedge clk);
    chk("dyn_fpu_rm", 32'(fpu_rm), 32'h2);
    chk("dyn_fpu_op", 32'(fpu_op), 32'h02);
    chk("dyn_fpu_a", fpu_a, 32'h40000000);
    wait_resp(lat);
    tick();
    @(negedge clk);
    chk("dyn_acc", 32'(fflags_acc), 32'h09);
    tick();

    // Dynamic rm with frm=101 is illegal
    frm = 3'b101;
    stub_lat = 0; stub_result = 32'hDEADBEEF; stub_flags = 5'b11111;
    push(32'h00000000, 5'd4, 5'b00000, 1'b1);
    base = start_total;
    send(OP_FADD, 3'b111, 32'h3F800000, 32'h3F800000, 5'd4);
    wait_resp(lat);
    chk("illegal_latency", 32'(lat), 32'd1);
    tick();
    @(negedge clk);
    chk("illegal_acc", 32'(fflags_acc), 32'h09);
    tick();
    chk("illegal_starts", 32'(start_total - base), 32'd0);

    // Non-rounding op keeps rm=111 as function select even with frm=101
    stub_result = 32'hBF800000; stub_flags = 5'b00000;
    push(32'hBF800000, 5'd5, 5'b00000, 1'b0);
    send(OP_FSGNJ, 3'b111, 32'h3F800000, 32'hBF800000, 5'd5);
    @(negedge clk);
    chk("sgnj_fpu_rm", 32'(fpu_rm), 32'h7);
    wait_resp(lat);
    tick(); tick();

    // Explicit reserved rm on a rounding op
    frm = 3'b000;
    push(32'h00000000, 5'd6, 5'b00000, 1'b1);
    send(OP_FSUB, 3'b110, 32'h3F800000, 32'h3F800000, 5'd6);
    wait_resp(lat);
    chk("rm110_latency", 32'(lat), 32'd1);
    tick(); tick();

    // Back-pressure: response held 3+ cycles, next request waits for handshake
    resp_ready = 1'b0;
    stub_lat = 0; stub_result = 32'h11111111; stub_flags = 5'b00100;
    push(32'h11111111, 5'd7, 5'b00100, 1'b0);
    send(OP_FMUL, 3'b000, 32'h40000000, 32'h40000000, 5'd7);
    wait_resp(lat);
    chk("hold_latency", 32'(lat), 32'd2);
    req_op = OP_FADD; req_rm = 3'b000; req_a = 32'h1; req_b = 32'h2; req_rd = 5'd8;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'h1);
      chk("hold_data", resp_data, 32'h11111111);
      chk("hold_rd", 32'(resp_rd), 32'd7);
      chk("hold_flags", 32'(resp_flags), 32'h04);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
    end
    push(32'h11111111, 5'd8, 5'b00100, 1'b0);
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_req_ready", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("after_hs_req_ready", 32'(req_ready), 32'h1);
    chk("after_hs_resp_valid", 32'(resp_valid), 32'h0);
    tick();
    req_valid = 1'b0;
    wait_resp(lat);
    chk("second_latency", 32'(lat), 32'd2);
    tick();
    @(negedge clk);
    chk("hold_acc", 32'(fflags_acc), 32'h0D);
    tick();

    // Flush during the third EXEC cycle of a long FSQRT
    stub_lat = 20;
    base = start_total;
    send(OP_FSQRT, 3'b000, 32'h40800000, 32'h0, 5'd9);
    tick(); tick();
    flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_start", 32'(fpu_start), 32'h1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_start", 32'(fpu_start), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("flush_no_resp", 32'(resp_valid), 32'h0);
    end
    chk("flush_idle_ready", 32'(req_ready), 32'h1);
    chk("flush_acc", 32'(fflags_acc), 32'h0D);
    tick();
    chk("flush_starts", 32'(start_total - base), 32'd3);

    // Flush in IDLE blocks acceptance
    req_op = OP_FADD; req_rm = 3'b000; req_rd = 5'd9; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_req_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_start", 32'(fpu_start), 32'h0);
    tick();

    // Fresh request after flush gets its own start pulse
    stub_lat = 0; stub_result = 32'h40000000; stub_flags = 5'b00000;
    push(32'h40000000, 5'd10, 5'b00000, 1'b0);
    base = start_total;
    send(OP_FSQRT, 3'b000, 32'h40800000, 32'h0, 5'd10);
    @(negedge clk);
    chk("fresh_start", 32'(fpu_start), 32'h1);
    wait_resp(lat);
    tick(); tick();
    chk("fresh_starts", 32'(start_total - base), 32'd1);

    // Clear alone
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    @(negedge clk);
    chk("clr_alone", 32'(fflags_acc), 32'h00);
    tick();

    // Accumulate NX, then clear coinciding with an NV handshake
    stub_result = 32'h3F800000; stub_flags = 5'b00001;
    push(32'h3F800000, 5'd11, 5'b00001, 1'b0);
    send(OP_FADD, 3'b000, 32'h3F800000, 32'h0, 5'd11);
    wait_resp(lat);
    tick();
    @(negedge clk);
    chk("nx_acc", 32'(fflags_acc), 32'h01);
    tick();
    resp_ready = 1'b0;
    stub_result = 32'h7FC00000; stub_flags = 5'b10000;
    push(32'h7FC00000, 5'd12, 5'b10000, 1'b0);
    send(OP_FDIV, 3'b000, 32'h0, 32'h0, 5'd12);
    wait_resp(lat);
    tick();
    fflags_clr = 1'b1;
    resp_ready = 1'b1;
    tick();
    fflags_clr = 1'b0;
    @(negedge clk);
    chk("clr_with_hs_acc", 32'(fflags_acc), 32'h10);
    tick();

    // Reset in the middle of EXEC
    stub_lat = 20;
    send(OP_FDIV, 3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd13);
    tick(); tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rstx_fpu_start", 32'(fpu_start), 32'h0);
    chk("rstx_resp_valid", 32'(resp_valid), 32'h0);
    chk("rstx_req_ready", 32'(req_ready), 32'h0);
    chk("rstx_fpu_a", fpu_a, 32'h0);
    chk("rstx_fpu_b", fpu_b, 32'h0);
    chk("rstx_fpu_op", 32'(fpu_op), 32'h0);
    chk("rstx_fpu_rm", 32'(fpu_rm), 32'h0);
    chk("rstx_resp_data", resp_data, 32'h0);
    chk("rstx_resp_rd", 32'(resp_rd), 32'h0);
    chk("rstx_acc", 32'(fflags_acc), 32'h0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("rstx_no_resp", 32'(resp_valid), 32'h0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
